// File: rtl/branch_predictor_sa.sv
// branch_predictor_sa: set-associative BTB with per-set round-robin victims,
// gshare-indexed 2-bit BHT and a circular return address stack. Lookups are
// combinational; all state changes at the clock edge, so a same-cycle update
// is invisible to the lookup that shares its edge.
module branch_predictor_sa #(
  parameter int VADDR_WIDTH = 39,
  parameter int BTB_SETS    = 64,
  parameter int BTB_WAYS    = 4,
  parameter int BHT_ENTRIES = 1024,
  parameter int GHR_LEN     = 10,
  parameter int RAS_DEPTH   = 8,
  localparam int RP         = $clog2(RAS_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   predict_valid,
  input  logic [VADDR_WIDTH-1:0] predict_pc,
  output logic                   pred_hit,
  output logic                   pred_taken,
  output logic [VADDR_WIDTH-1:0] pred_target,
  output logic                   pred_is_call,
  output logic                   pred_is_ret,
  output logic [1:0]             pred_confidence,
  output logic [GHR_LEN-1:0]     pred_ghr,
  output logic [RP-1:0]          pred_ras_ptr,
  input  logic                   update_valid,
  input  logic [VADDR_WIDTH-1:0] update_pc,
  input  logic [VADDR_WIDTH-1:0] update_target,
  input  logic                   update_taken,
  input  logic                   update_mispredicted,
  input  logic                   update_is_cond,
  input  logic                   update_is_call,
  input  logic                   update_is_ret,
  input  logic [GHR_LEN-1:0]     update_ghr,
  input  logic [RP-1:0]          update_ras_ptr
);

  localparam int SET_W = $clog2(BTB_SETS);
  localparam int TAG_W = VADDR_WIDTH - SET_W - 2;
  localparam int BHT_W = $clog2(BHT_ENTRIES);
  localparam int WAY_W = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;

  typedef struct packed {
    logic                   valid;
    logic [TAG_W-1:0]       tag;
    logic [VADDR_WIDTH-1:0] target;
    logic                   is_call;
    logic                   is_ret;
    logic                   is_cond;
  } btb_entry_t;

  localparam btb_entry_t BTB_ENTRY_RST = btb_entry_t'({$bits(btb_entry_t){1'b0}});

  // Architectural state (_q) and its next value (_d)
  btb_entry_t             btb_q    [BTB_SETS][BTB_WAYS];
  btb_entry_t             btb_d    [BTB_SETS][BTB_WAYS];
  logic [WAY_W-1:0]       victim_q [BTB_SETS];
  logic [WAY_W-1:0]       victim_d [BTB_SETS];
  logic [1:0]             bht_q    [BHT_ENTRIES];
  logic [1:0]             bht_d    [BHT_ENTRIES];
  logic [VADDR_WIDTH-1:0] ras_q    [RAS_DEPTH];
  logic [VADDR_WIDTH-1:0] ras_d    [RAS_DEPTH];
  logic [GHR_LEN-1:0]     ghr_q, ghr_d;
  logic [RP-1:0]          ras_ptr_q, ras_ptr_d;

  // Fetch-side lookup signals
  logic [SET_W-1:0] look_set_s;
  logic [TAG_W-1:0] look_tag_s;
  logic [BHT_W-1:0] look_bht_idx_s;
  logic             look_hit_s;
  btb_entry_t       look_entry_s;
  logic             look_ret_s;
  logic             look_call_s;
  logic             look_cond_s;

  // Resolve-side signals
  logic [SET_W-1:0] upd_set_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic [BHT_W-1:0] upd_bht_idx_s;
  logic             upd_hit_s;
  logic [WAY_W-1:0] upd_hit_way_s;
  logic             upd_free_s;
  logic [WAY_W-1:0] upd_free_way_s;
  logic [WAY_W-1:0] upd_way_s;
  logic             btb_we_s;
  logic             mispredict_s;

  // Instruction-alignment bits never take part in indexing
  logic             unused_pc_bits_s;

  assign unused_pc_bits_s = ^{predict_pc[1:0], update_pc[1:0]};

  assign look_set_s     = predict_pc[SET_W+1:2];
  assign look_tag_s     = predict_pc[VADDR_WIDTH-1:SET_W+2];
  assign look_bht_idx_s = predict_pc[BHT_W+1:2] ^ BHT_W'(ghr_q);

  assign upd_set_s      = update_pc[SET_W+1:2];
  assign upd_tag_s      = update_pc[VADDR_WIDTH-1:SET_W+2];
  assign upd_bht_idx_s  = update_pc[BHT_W+1:2] ^ BHT_W'(update_ghr);
  assign mispredict_s   = update_valid & update_mispredicted;
  assign btb_we_s       = update_valid & (update_taken | update_mispredicted);

  // Associative tag search of the fetch set; a tag is held by at most one way
  always_comb begin
    look_hit_s   = 1'b0;
    look_entry_s = BTB_ENTRY_RST;
    for (int w = 0; w < BTB_WAYS; w++) begin
      if (predict_valid && btb_q[look_set_s][w].valid &&
          (btb_q[look_set_s][w].tag == look_tag_s)) begin
        look_hit_s   = 1'b1;
        look_entry_s = btb_q[look_set_s][w];
      end else begin
        look_hit_s   = look_hit_s;
        look_entry_s = look_entry_s;
      end
    end
  end

  // Returns take priority; calls count as unconditional even if flagged conditional
  assign look_ret_s  = look_hit_s & look_entry_s.is_ret;
  assign look_call_s = look_hit_s & look_entry_s.is_call & ~look_entry_s.is_ret;
  assign look_cond_s = look_hit_s & look_entry_s.is_cond & ~look_entry_s.is_call &
                       ~look_entry_s.is_ret;

  // Prediction outputs: all zero on a miss, checkpoints always reflect live state
  always_comb begin
    pred_hit        = 1'b0;
    pred_taken      = 1'b0;
    pred_target     = {VADDR_WIDTH{1'b0}};
    pred_is_call    = 1'b0;
    pred_is_ret     = 1'b0;
    pred_confidence = 2'b00;
    if (look_hit_s) begin
      pred_hit        = 1'b1;
      pred_is_call    = look_entry_s.is_call;
      pred_is_ret     = look_entry_s.is_ret;
      pred_confidence = bht_q[look_bht_idx_s];
      if (look_ret_s) begin
        pred_taken  = 1'b1;
        pred_target = ras_q[ras_ptr_q - RP'(1'b1)];
      end else if (look_cond_s) begin
        pred_taken  = bht_q[look_bht_idx_s][1];
        pred_target = look_entry_s.target;
      end else begin
        pred_taken  = 1'b1;
        pred_target = look_entry_s.target;
      end
    end else begin
      pred_hit = 1'b0;
    end
  end

  assign pred_ghr     = ghr_q;
  assign pred_ras_ptr = ras_ptr_q;

  // Speculative GHR/RAS movement, overridden entirely by mispredict recovery
  always_comb begin
    ghr_d     = ghr_q;
    ras_ptr_d = ras_ptr_q;
    ras_d     = ras_q;
    if (mispredict_s) begin
      if (update_is_cond) begin
        ghr_d = {update_ghr[GHR_LEN-2:0], update_taken};
      end else begin
        ghr_d = update_ghr;
      end
      if (update_is_call && update_taken) begin
        ras_d[update_ras_ptr] = update_pc + VADDR_WIDTH'(3'd4);
        ras_ptr_d             = update_ras_ptr + RP'(1'b1);
      end else if (update_is_ret && update_taken) begin
        ras_ptr_d = update_ras_ptr - RP'(1'b1);
      end else begin
        ras_ptr_d = update_ras_ptr;
      end
    end else begin
      if (look_cond_s) begin
        ghr_d = {ghr_q[GHR_LEN-2:0], pred_taken};
      end else begin
        ghr_d = ghr_q;
      end
      if (look_call_s) begin
        ras_d[ras_ptr_q] = predict_pc + VADDR_WIDTH'(3'd4);
        ras_ptr_d        = ras_ptr_q + RP'(1'b1);
      end else if (look_ret_s) begin
        ras_ptr_d = ras_ptr_q - RP'(1'b1);
      end else begin
        ras_ptr_d = ras_ptr_q;
      end
    end
  end

  // Saturating 2-bit counter training for resolved conditional branches
  always_comb begin
    bht_d = bht_q;
    if (update_valid && update_is_cond) begin
      if (update_taken) begin
        if (bht_q[upd_bht_idx_s] != 2'b11) begin
          bht_d[upd_bht_idx_s] = bht_q[upd_bht_idx_s] + 2'b01;
        end else begin
          bht_d[upd_bht_idx_s] = 2'b11;
        end
      end else begin
        if (bht_q[upd_bht_idx_s] != 2'b00) begin
          bht_d[upd_bht_idx_s] = bht_q[upd_bht_idx_s] - 2'b01;
        end else begin
          bht_d[upd_bht_idx_s] = 2'b00;
        end
      end
    end else begin
      bht_d = bht_q;
    end
  end

  // Way choice for BTB allocation: own tag, else lowest free way, else victim
  always_comb begin
    upd_hit_s      = 1'b0;
    upd_hit_way_s  = {WAY_W{1'b0}};
    upd_free_s     = 1'b0;
    upd_free_way_s = {WAY_W{1'b0}};
    for (int w = 0; w < BTB_WAYS; w++) begin
      if (btb_q[upd_set_s][w].valid && (btb_q[upd_set_s][w].tag == upd_tag_s)) begin
        upd_hit_s     = 1'b1;
        upd_hit_way_s = WAY_W'(w);
      end else begin
        upd_hit_s     = upd_hit_s;
        upd_hit_way_s = upd_hit_way_s;
      end
    end
    // Scan downwards so the lowest-index free way is the one left standing
    for (int w = BTB_WAYS - 1; w >= 0; w--) begin
      if (!btb_q[upd_set_s][w].valid) begin
        upd_free_s     = 1'b1;
        upd_free_way_s = WAY_W'(w);
      end else begin
        upd_free_s     = upd_free_s;
        upd_free_way_s = upd_free_way_s;
      end
    end
    if (upd_hit_s) begin
      upd_way_s = upd_hit_way_s;
    end else if (upd_free_s) begin
      upd_way_s = upd_free_way_s;
    end else begin
      upd_way_s = victim_q[upd_set_s];
    end
  end

  // BTB entry write and round-robin advance when a victim is displaced
  always_comb begin
    btb_d    = btb_q;
    victim_d = victim_q;
    if (btb_we_s) begin
      btb_d[upd_set_s][upd_way_s] = '{valid:   1'b1,
                                      tag:     upd_tag_s,
                                      target:  update_target,
                                      is_call: update_is_call,
                                      is_ret:  update_is_ret,
                                      is_cond: update_is_cond};
      if (!upd_hit_s && !upd_free_s) begin
        victim_d[upd_set_s] = (victim_q[upd_set_s] == WAY_W'(BTB_WAYS - 1)) ?
                              {WAY_W{1'b0}} : victim_q[upd_set_s] + WAY_W'(1'b1);
      end else begin
        victim_d[upd_set_s] = victim_q[upd_set_s];
      end
    end else begin
      btb_d = btb_q;
    end
  end

  // State registers; BHT powers up weakly not-taken, everything else cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_q     <= '{default: '{default: BTB_ENTRY_RST}};
      victim_q  <= '{default: {WAY_W{1'b0}}};
      bht_q     <= '{default: 2'b01};
      ras_q     <= '{default: {VADDR_WIDTH{1'b0}}};
      ghr_q     <= {GHR_LEN{1'b0}};
      ras_ptr_q <= {RP{1'b0}};
    end else begin
      btb_q     <= btb_d;
      victim_q  <= victim_d;
      bht_q     <= bht_d;
      ras_q     <= ras_d;
      ghr_q     <= ghr_d;
      ras_ptr_q <= ras_ptr_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_sa.sv
// Scoreboard bench for branch_predictor_sa: the driver computes the expected
// lookup result from an abstract model and queues it; a monitor compares it
// against the DUT on the falling edge of the same cycle.
module tb_branch_predictor_sa;
  localparam int VA   = 39;
  localparam int SETS = 64;
  localparam int WAYS = 4;
  localparam int BHTN = 1024;
  localparam int GL   = 10;
  localparam int RD   = 8;
  localparam int RPW  = 3;
  localparam int SETB = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          predict_valid = 1'b0;
  logic [VA-1:0] predict_pc = '0;
  logic          pred_hit, pred_taken, pred_is_call, pred_is_ret;
  logic [VA-1:0] pred_target;
  logic [1:0]    pred_confidence;
  logic [GL-1:0] pred_ghr;
  logic [RPW-1:0] pred_ras_ptr;
  logic          update_valid = 1'b0;
  logic [VA-1:0] update_pc = '0, update_target = '0;
  logic          update_taken = 1'b0, update_mispredicted = 1'b0;
  logic          update_is_cond = 1'b0, update_is_call = 1'b0, update_is_ret = 1'b0;
  logic [GL-1:0] update_ghr = '0;
  logic [RPW-1:0] update_ras_ptr = '0;

  always #5 clk = ~clk;

  branch_predictor_sa #(
    .VADDR_WIDTH(VA), .BTB_SETS(SETS), .BTB_WAYS(WAYS),
    .BHT_ENTRIES(BHTN), .GHR_LEN(GL), .RAS_DEPTH(RD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .predict_valid(predict_valid), .predict_pc(predict_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_is_call(pred_is_call), .pred_is_ret(pred_is_ret),
    .pred_confidence(pred_confidence), .pred_ghr(pred_ghr), .pred_ras_ptr(pred_ras_ptr),
    .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
    .update_taken(update_taken), .update_mispredicted(update_mispredicted),
    .update_is_cond(update_is_cond), .update_is_call(update_is_call),
    .update_is_ret(update_is_ret), .update_ghr(update_ghr), .update_ras_ptr(update_ras_ptr)
  );

  typedef struct {
    bit            hit;
    bit            taken;
    logic [VA-1:0] target;
    bit            call;
    bit            ret;
    int            conf;
    int            ghr;
    int            rp;
    bit            cond_kind;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference model: plain arrays and integer arithmetic
  bit            m_valid [SETS][WAYS];
  logic [VA-1:0] m_tag   [SETS][WAYS];
  logic [VA-1:0] m_tgt   [SETS][WAYS];
  bit            m_call  [SETS][WAYS];
  bit            m_ret   [SETS][WAYS];
  bit            m_cond  [SETS][WAYS];
  int            m_victim[SETS];
  int            m_bht   [BHTN];
  logic [VA-1:0] m_ras   [RD];
  int            m_ghr;
  int            m_rp;

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_victim[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
    for (int i = 0; i < BHTN; i++) m_bht[i] = 1;
    for (int i = 0; i < RD; i++) m_ras[i] = '0;
    m_ghr = 0;
    m_rp  = 0;
  endfunction

  function automatic int set_of(logic [VA-1:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic exp_t model_lookup(bit pv, logic [VA-1:0] pc);
    exp_t e;
    int   s, hw;
    e.hit = 0; e.taken = 0; e.target = '0; e.call = 0; e.ret = 0;
    e.conf = 0; e.cond_kind = 0; e.ghr = m_ghr; e.rp = m_rp;
    if (!pv) return e;
    s  = set_of(pc);
    hw = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == (pc >> (SETB + 2))) hw = w;
    if (hw < 0) return e;
    e.hit  = 1;
    e.call = m_call[s][hw];
    e.ret  = m_ret[s][hw];
    e.conf = m_bht[int'((pc >> 2) % BHTN) ^ m_ghr];
    if (e.ret) begin
      e.taken  = 1;
      e.target = m_ras[(m_rp + RD - 1) % RD];
    end else if (e.call || !m_cond[s][hw]) begin
      e.taken  = 1;
      e.target = m_tgt[s][hw];
    end else begin
      e.taken     = (e.conf >= 2);
      e.target    = m_tgt[s][hw];
      e.cond_kind = 1;
    end
    return e;
  endfunction

  function automatic void model_step(exp_t e, logic [VA-1:0] ppc, bit uv,
                                     logic [VA-1:0] upc, logic [VA-1:0] utgt,
                                     bit ut, bit um, bit uc, bit ucall, bit uret,
                                     int ughr, int urp);
    int idx, s, way;
    if (uv && uc) begin
      idx = int'((upc >> 2) % BHTN) ^ ughr;
      if (ut) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
      else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
    end
    if (uv && (ut || um)) begin
      s   = set_of(upc);
      way = -1;
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_tag[s][w] == (upc >> (SETB + 2))) way = w;
      for (int w = 0; w < WAYS; w++)
        if (way < 0 && !m_valid[s][w]) way = w;
      if (way < 0) begin
        way = m_victim[s];
        m_victim[s] = (way + 1) % WAYS;
      end
      m_valid[s][way] = 1;
      m_tag[s][way]   = upc >> (SETB + 2);
      m_tgt[s][way]   = utgt;
      m_call[s][way]  = ucall;
      m_ret[s][way]   = uret;
      m_cond[s][way]  = uc;
    end
    if (uv && um) begin
      m_ghr = uc ? ((ughr * 2) + int'(ut)) % (1 << GL) : ughr;
      if (ucall && ut) begin
        m_ras[urp] = upc + 4;
        m_rp = (urp + 1) % RD;
      end else if (uret && ut) begin
        m_rp = (urp + RD - 1) % RD;
      end else begin
        m_rp = urp;
      end
    end else begin
      if (e.cond_kind) m_ghr = ((m_ghr * 2) + int'(e.taken)) % (1 << GL);
      if (e.hit && e.ret) begin
        m_rp = (m_rp + RD - 1) % RD;
      end else if (e.hit && e.call) begin
        m_ras[m_rp] = ppc + 4;
        m_rp = (m_rp + 1) % RD;
      end
    end
  endfunction

  // One clock of stimulus: drive, queue the expected response, advance the model
  task automatic drive(input bit pv, input logic [VA-1:0] ppc, input bit uv,
                       input logic [VA-1:0] upc, input logic [VA-1:0] utgt,
                       input bit ut, input bit um, input bit uc, input bit ucall,
                       input bit uret, input int ughr, input int urp);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    predict_valid = pv; predict_pc = ppc;
    update_valid = uv; update_pc = upc; update_target = utgt;
    update_taken = ut; update_mispredicted = um; update_is_cond = uc;
    update_is_call = ucall; update_is_ret = uret;
    update_ghr = GL'(ughr); update_ras_ptr = RPW'(urp);
    e = model_lookup(pv, ppc);
    exp_q.push_back(e);
    model_step(e, ppc, uv, upc, utgt, ut, um, uc, ucall, uret, ughr, urp);
  endtask

  task automatic lookup(input logic [VA-1:0] pc);
    drive(1'b1, pc, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic update(input logic [VA-1:0] pc, input logic [VA-1:0] tgt, input bit ut,
                        input bit um, input bit uc, input bit ucall, input bit uret,
                        input int ughr, input int urp);
    drive(1'b0, '0, 1'b1, pc, tgt, ut, um, uc, ucall, uret, ughr, urp);
  endtask

  // Asynchronous reset in mid-cycle, with lookups held active to observe misses
  task automatic apply_reset(input int cycles, input logic [VA-1:0] probe_pc);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      predict_valid = 1'b1; predict_pc = probe_pc;
      update_valid = 1'b0;
      model_reset();
      exp_q.push_back(model_lookup(1'b1, probe_pc));
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (pred_hit !== e.hit || pred_taken !== e.taken || pred_target !== e.target ||
            pred_is_call !== e.call || pred_is_ret !== e.ret ||
            pred_confidence !== 2'(e.conf) || pred_ghr !== GL'(e.ghr) ||
            pred_ras_ptr !== RPW'(e.rp)) begin
          tests_failed++;
          $display("FAIL lookup#%0d pc=%h: got hit=%0b tk=%0b tgt=%h call=%0b ret=%0b conf=%0d ghr=%h rp=%0d; want hit=%0b tk=%0b tgt=%h call=%0b ret=%0b conf=%0d ghr=%h rp=%0d",
                   tests_run, predict_pc, pred_hit, pred_taken, pred_target, pred_is_call,
                   pred_is_ret, pred_confidence, pred_ghr, pred_ras_ptr, e.hit, e.taken,
                   e.target, e.call, e.ret, e.conf, e.ghr[GL-1:0], e.rp);
        end
      end
    end
  end

  logic [VA-1:0] pool [12];

  initial begin
    model_reset();
    apply_reset(2, VA'(32'h1000));

    // Conditional branch trained twice -> strongly taken
    update(VA'(32'h1000), VA'(32'h2000), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    update(VA'(32'h1000), VA'(32'h2000), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    lookup(VA'(32'h1000));

    // Five tags into set 0: fifth replaces way 0
    for (int k = 0; k < 5; k++)
      update(VA'(32'h4000 + k * 32'h100), VA'(32'h8000 + k * 32'h10),
             1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 5; k++) lookup(VA'(32'h4000 + k * 32'h100));

    // Reset mid-stream: everything misses, BHT back to 01
    apply_reset(2, VA'(32'h4100));
    for (int k = 0; k < 5; k++) lookup(VA'(32'h4000 + k * 32'h100));
    update(VA'(32'h1000), VA'(32'h2000), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    lookup(VA'(32'h1000));

    // Call/return stack, including wrap-around after nine pushes
    apply_reset(1, VA'(32'h100));
    update(VA'(32'h100), VA'(32'h5000), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    update(VA'(32'h200), VA'(32'h6000), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    update(VA'(32'h300), VA'(32'h7000), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    lookup(VA'(32'h100));
    lookup(VA'(32'h200));
    lookup(VA'(32'h300));
    lookup(VA'(32'h300));
    for (int k = 0; k < 9; k++) lookup((k % 2 == 0) ? VA'(32'h100) : VA'(32'h200));
    for (int k = 0; k < 3; k++) lookup(VA'(32'h300));

    // Mispredict recovery beats a same-cycle GHR shift
    apply_reset(1, VA'(32'h1000));
    update(VA'(32'h1000), VA'(32'h2000), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    lookup(VA'(32'h1000));
    drive(1'b1, VA'(32'h1000), 1'b1, VA'(32'h1000), VA'(32'h2000),
          1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    lookup(VA'(32'h1000));

    // Mispredict recovery restores the RAS pointer checkpoint
    apply_reset(1, VA'(32'h100));
    update(VA'(32'h100), VA'(32'h5000), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++) lookup(VA'(32'h100));
    update(VA'(32'h1000), VA'(32'h2000), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 3);
    lookup(VA'(32'h100));

    // Randomised traffic over two crowded sets
    for (int k = 0; k < 12; k++) pool[k] = VA'(((k % 6) << (SETB + 2)) | ((k / 6) << 2));
    for (int n = 0; n < 800; n++) begin
      int ty;
      ty = $urandom_range(0, 3);
      if ($urandom_range(0, 249) == 0) begin
        apply_reset(1, pool[$urandom_range(0, 11)]);
      end else begin
        drive($urandom_range(0, 3) != 0, pool[$urandom_range(0, 11)],
              $urandom_range(0, 1) == 1, pool[$urandom_range(0, 11)],
              VA'({$urandom_range(0, 32'h3fff_ffff), 2'b00}),
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              ty == 0, ty == 1, ty == 2,
              int'($urandom_range(0, (1 << GL) - 1)), int'($urandom_range(0, RD - 1)));
      end
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_predictor_sa.md
BRANCH_PREDICTOR_SA -- requirements
Module: branch_predictor_sa

Interface
REQ-001 SHALL have parameter VADDR_WIDTH, default 39, virtual address width.
REQ-002 SHALL have parameter BTB_SETS, default 64, BTB sets (power of 2).
REQ-003 SHALL have parameter BTB_WAYS, default 4, BTB associativity (power of 2, 1..8).
REQ-004 SHALL have parameter BHT_ENTRIES, default 1024, 2-bit counters (power of 2).
REQ-005 SHALL have parameter GHR_LEN, default 10, history bits (2 <= GHR_LEN <= log2(BHT_ENTRIES)).
REQ-006 SHALL have parameter RAS_DEPTH, default 8, return stack entries (power of 2); RP = log2(RAS_DEPTH).
REQ-007 SHALL use a single clock and an asynchronous active-low reset, ports clk and rst_n.
REQ-008 SHALL have ports as follows (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- predict_valid  in  1  fetch lookup request
- predict_pc  in  VADDR_WIDTH  fetch PC
- pred_hit  out  1  BTB hit
- pred_taken  out  1  predicted taken
- pred_target  out  VADDR_WIDTH  predicted target
- pred_is_call / pred_is_ret  out  1 each  entry type
- pred_confidence  out  2  BHT counter value
- pred_ghr  out  GHR_LEN  GHR checkpoint, pre-shift
- pred_ras_ptr  out  RP  RAS pointer checkpoint, pre-push/pop
- update_valid  in  1  resolved branch
- update_pc / update_target  in  VADDR_WIDTH each  branch PC / actual target
- update_taken, update_mispredicted, update_is_cond, update_is_call, update_is_ret  in  1 each  outcome and type
- update_ghr  in  GHR_LEN  checkpoint returned with branch
- update_ras_ptr  in  RP  checkpoint returned with branch

Function
REQ-009 SHALL index: set = predict_pc[log2(BTB_SETS)+1:2]; tag = predict_pc[VADDR_WIDTH-1:log2(BTB_SETS)+2]; bht_idx = predict_pc[log2(BHT_ENTRIES)+1:2] XOR zero-extended ghr.
REQ-010 SHALL assert pred_hit combinationally when predict_valid and a valid way in the set matches tag; at most one way matches.
REQ-011 SHALL drive all pred_* outputs except pred_ghr and pred_ras_ptr to 0 when pred_hit=0; pred_ghr/pred_ras_ptr always show current state.
REQ-012 SHALL on hit: ret -> taken=1, target=ras[ras_ptr-1 mod RAS_DEPTH]; unconditional (call or non-cond) -> taken=1, target=BTB target; conditional -> taken=counter[1], target=BTB target.
REQ-013 SHALL on edge with predict_valid, hit and conditional, shift ghr <= {ghr[GHR_LEN-2:0], pred_taken}; unconditional hits do not shift.
REQ-014 SHALL on predicted call write ras[ras_ptr] <= predict_pc+4 and ras_ptr+1; on predicted ret ras_ptr-1; pointer wraps mod RAS_DEPTH, overflow overwrites oldest entry silently.
REQ-015 SHALL on update_valid and update_is_cond update bht[update_pc bits XOR update_ghr] with 2-bit saturating counter (11 max, 00 min).
REQ-016 SHALL on update_valid and (update_taken or update_mispredicted) write BTB: matching way if tag hit, else lowest-index invalid way, else way given by the set's round-robin victim pointer, which then increments mod BTB_WAYS.
REQ-017 SHALL store entry type is_call, is_ret, is_cond=update_is_cond with the target.
REQ-018 SHALL on update_valid and update_mispredicted restore ghr <= update_is_cond ? {update_ghr[GHR_LEN-2:0], update_taken} : update_ghr.
REQ-019 SHALL on mispredict restore ras_ptr: call&taken -> update_ras_ptr+1 with ras[update_ras_ptr] <= update_pc+4; ret&taken -> update_ras_ptr-1; otherwise update_ras_ptr.
REQ-020 SHALL give mispredict recovery priority over same-cycle prediction GHR shift and RAS push/pop (prediction-side changes dropped).
REQ-021 SHALL leave ghr and ras_ptr unaffected by non-mispredicted updates.
REQ-022 SHALL serve same-cycle lookup of an entry being updated with the pre-update value (write at edge).

Reset
REQ-023 SHALL on rst_n=0 asynchronously clear all BTB valid bits, victim pointers, ghr, ras_ptr, RAS contents to 0 and set all BHT counters to 01; pred_* outputs 0 (pred_hit=0).
REQ-024 SHALL resume normal lookup on the first edge after rst_n deasserts; reset mid-operation discards all state.

Verification
REQ-025 Cond branch PC 0x1000 taken, target 0x2000, update x2 with ghr=0 -> lookup with ghr=0: hit, counter 11, taken=1, target 0x2000.
REQ-026 Five distinct taken tags into one set, BTB_WAYS=4 -> ways 0-3 filled, fifth evicts way 0; first tag misses, others hit.
REQ-027 Predicted calls at 0x100, 0x200, RAS_DEPTH=8 -> ret lookup targets 0x204 then 0x104; nine pushes -> oldest overwritten, ninth ret returns most recent.
REQ-028 Cond predict shifts ghr 0->1; mispredict update with update_ghr=0, taken=0, same-cycle new prediction -> ghr=0, prediction shift dropped.
REQ-029 Call predicted (ras_ptr 3->4), mispredict update with update_is_call=0, update_ras_ptr=3 -> ras_ptr=3.
REQ-030 Assert rst_n mid-stream after BTB fills -> all lookups miss, BHT counters read 01.
